lse_div: RTL and testbench
==========================

LSE_DIV -- requirements
Module: lse_div

Interface
REQ-001 Parameter WIDTH, default 24, total operand/result bit width; all values below are for WIDTH=24.
REQ-002 Parameter CNT_W, default 8, width of the divide-by-zero event counter.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-high.
REQ-005 i_valid  input  1  upstream operand pair valid.
REQ-006 o_ready  output  1  block can accept an operand pair this cycle.
REQ-007 i_operand_a  input  WIDTH  dividend, log-space, two's complement.
REQ-008 i_operand_b  input  WIDTH  divisor, log-space, two's complement.
REQ-009 o_valid  output  1  result valid.
REQ-010 i_ready  input  1  downstream accepts result this cycle.
REQ-011 o_result  output  WIDTH  quotient, log-space: log(a/b) = a - b.
REQ-012 o_div_zero  output  1  qualifies o_result; divisor was -inf.
REQ-013 o_sat  output  1  qualifies o_result; finite difference was clamped.
REQ-014 o_dz_count  output  CNT_W  saturating count of delivered divide-by-zero results.

Function
REQ-015 NEG_INF shall be 24'h800000 (log 0); most-positive finite value MAX_POS = 24'h7FFFFF; most-negative finite value MIN_FIN = 24'h800001.
REQ-016 Input transfer shall occur when i_valid && o_ready; output transfer shall occur when o_valid && i_ready.
REQ-017 Pipeline shall have two register stages: S1 captures operands plus 25-bit signed difference a - b; S2 holds saturated result and flags.
REQ-018 Latency shall be 2 cycles from input transfer to o_valid with no backpressure; throughput one pair per cycle.
REQ-019 S2 shall load when S1 valid and (S2 empty or output transfer this cycle); S1 shall load on input transfer.
REQ-020 o_ready shall equal !S1_valid || !S2_valid || i_ready (combinational from i_ready permitted).
REQ-021 While o_valid && !i_ready, o_result, o_div_zero and o_sat shall hold stable.
REQ-022 Results shall emerge in acceptance order; no pair dropped or duplicated under any i_valid/i_ready pattern.
REQ-023 b == NEG_INF, a finite: o_result = MAX_POS, o_div_zero = 1, o_sat = 0.
REQ-024 a == NEG_INF, b == NEG_INF: o_result = NEG_INF, o_div_zero = 1, o_sat = 0.
REQ-025 a == NEG_INF, b finite: o_result = NEG_INF, o_div_zero = 0, o_sat = 0.
REQ-026 Both finite: diff > MAX_POS -> MAX_POS with o_sat = 1; diff < -(2^23-1) -> MIN_FIN with o_sat = 1; else diff, o_sat = 0; result never equals NEG_INF.
REQ-027 o_dz_count shall increment by 1 on each output transfer with o_div_zero = 1 and hold at all-ones (no wrap).
REQ-028 When o_valid = 0, o_result, o_div_zero and o_sat shall be 0.

Reset
REQ-029 While i_rst = 1: S1_valid = S2_valid = 0, o_valid = 0, o_result = 0, o_div_zero = 0, o_sat = 0, o_dz_count = 0, o_ready = 1.
REQ-030 Reset asserted mid-operation shall discard all in-flight pairs; no result emerges after deassertion unless new input is accepted.
REQ-031 First input transfer shall be possible on the first rising edge after i_rst deasserts.

Verification
REQ-032 a=24'h000010, b=24'h000004, i_ready=1 -> o_valid 2 cycles later, o_result=24'h00000C, flags 0.
REQ-033 a=24'h7FFFF0, b=24'hFFFF00 -> o_result=24'h7FFFFF, o_sat=1; a=24'h800001, b=24'h000001 -> o_result=24'h800001, o_sat=1.
REQ-034 b=24'h800000 with a=24'h000005 then a=24'h800000 -> results 24'h7FFFFF then 24'h800000, o_div_zero=1 both, o_dz_count 0->1->2; 300 such transfers -> o_dz_count holds 8'hFF.
REQ-035 Stream 5 pairs with i_ready=0 for cycles 1-4 -> o_ready drops after 2 accepted, all 5 results delivered in order once i_ready=1, outputs stable while stalled.
REQ-036 Assert i_rst with both stages full -> all outputs zero asynchronously, o_ready=1; after release no spurious o_valid.

Source files
------------

// File: rtl/lse_div.sv
// ---------------------------------------------------------------------------
// lse_div -- log-space divider.
//
// Numbers are logarithms held as two's complement values. The most-negative
// code (NEG_INF) stands for log(0). Dividing in linear space is the same as
// subtracting in log space: log(a/b) = a - b. The finite result is clamped
// into [MIN_FIN, MAX_POS] so that it never collides with the NEG_INF code.
//
// Pipeline: S1 registers the operands and the (WIDTH+1)-bit difference.
// S2 registers the clamped result and its flags. Both stages use
// valid/ready handshakes with full throughput.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_valid      operand pair valid
//   o_ready      an operand pair can be accepted this cycle
//   i_operand_a  dividend (log space)
//   i_operand_b  divisor  (log space)
//   o_valid      result valid
//   i_ready      downstream takes the result this cycle
//   o_result     quotient (log space), zero when o_valid is low
//   o_div_zero   divisor was NEG_INF
//   o_sat        finite difference was clamped
//   o_dz_count   saturating count of delivered divide-by-zero results
// ---------------------------------------------------------------------------
module lse_div #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_operand_a,
    input  logic [WIDTH-1:0] i_operand_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_div_zero,
    output logic             o_sat,
    output logic [CNT_W-1:0] o_dz_count
);

    localparam logic [WIDTH-1:0] NEG_INF = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_FIN = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Returns {div_zero, sat, result} for one operand pair and its difference.
    function automatic logic [WIDTH+1:0] quot_calc(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH:0]   diff
    );
        logic [WIDTH-1:0] res;
        logic             dz;
        logic             sat;
        res = diff[WIDTH-1:0];
        dz  = 1'b0;
        sat = 1'b0;
        if (b == NEG_INF) begin
            dz  = 1'b1;
            res = (a == NEG_INF) ? NEG_INF : MAX_POS;
        end else if (a == NEG_INF) begin
            res = NEG_INF;
        end else if (diff[WIDTH:WIDTH-1] == 2'b01) begin
            // Difference reached +2^(W-1) or above.
            res = MAX_POS;
            sat = 1'b1;
        end else if ((diff[WIDTH:WIDTH-1] == 2'b10) || (diff == {1'b1, NEG_INF})) begin
            // Difference at or below -2^(W-1): that includes the NEG_INF code itself.
            res = MIN_FIN;
            sat = 1'b1;
        end else begin
            res = diff[WIDTH-1:0];
        end
        return {dz, sat, res};
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [WIDTH:0]   s1_diff_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] s2_result_r;
    logic             s2_dz_r;
    logic             s2_sat_r;
    logic [CNT_W-1:0] dz_cnt_r;

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             s2_load_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH+1:0] calc_s;

    assign o_ready    = !s1_valid_r || !s2_valid_r || i_ready;
    assign in_xfer_s  = i_valid && o_ready;
    assign out_xfer_s = s2_valid_r && i_ready;
    assign s2_load_s  = s1_valid_r && (!s2_valid_r || out_xfer_s);
    assign diff_s     = {i_operand_a[WIDTH-1], i_operand_a} - {i_operand_b[WIDTH-1], i_operand_b};
    assign calc_s     = quot_calc(s1_a_r, s1_b_r, s1_diff_r);

    // Stage 1: capture operands and their sign-extended difference.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_diff_r  <= {(WIDTH+1){1'b0}};
        end else if (in_xfer_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= i_operand_a;
            s1_b_r     <= i_operand_b;
            s1_diff_r  <= diff_s;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: clamped result and flags; cleared when drained so idle outputs read zero.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {WIDTH{1'b0}};
            s2_dz_r     <= 1'b0;
            s2_sat_r    <= 1'b0;
        end else if (s2_load_s) begin
            s2_valid_r  <= 1'b1;
            s2_result_r <= calc_s[WIDTH-1:0];
            s2_sat_r    <= calc_s[WIDTH];
            s2_dz_r     <= calc_s[WIDTH+1];
        end else if (out_xfer_s) begin
            s2_valid_r  <= 1'b0;
            s2_result_r <= {WIDTH{1'b0}};
            s2_dz_r     <= 1'b0;
            s2_sat_r    <= 1'b0;
        end else begin
            s2_valid_r  <= s2_valid_r;
        end
    end

    // Divide-by-zero event counter, counts delivered results and sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            dz_cnt_r <= {CNT_W{1'b0}};
        end else if (out_xfer_s && s2_dz_r && (dz_cnt_r != CNT_MAX)) begin
            dz_cnt_r <= dz_cnt_r + CNT_ONE;
        end else begin
            dz_cnt_r <= dz_cnt_r;
        end
    end

    assign o_valid    = s2_valid_r;
    assign o_result   = s2_result_r;
    assign o_div_zero = s2_dz_r;
    assign o_sat      = s2_sat_r;
    assign o_dz_count = dz_cnt_r;

endmodule

// File: tb/tb_lse_div.sv
// ---------------------------------------------------------------------------
// tb_lse_div -- directed self-checking bench for lse_div (WIDTH=24, CNT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_lse_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [23:0] op_a;
    logic [23:0] op_b;
    logic        out_valid;
    logic        down_ready;
    logic [23:0] result;
    logic        div_zero;
    logic        sat;
    logic [7:0]  dz_count;

    int n_checks;
    int n_fail;
    int exp_cnt;

    lse_div #(.WIDTH(24), .CNT_W(8)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (in_valid),
        .o_ready     (out_ready),
        .i_operand_a (op_a),
        .i_operand_b (op_b),
        .o_valid     (out_valid),
        .i_ready     (down_ready),
        .o_result    (result),
        .o_div_zero  (div_zero),
        .o_sat       (sat),
        .o_dz_count  (dz_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transfer with i_ready=1; called on a falling edge, returns on one.
    task automatic run_single(input string tag, input logic [23:0] a, input logic [23:0] b,
                              input logic [23:0] exp_res, input logic exp_dz, input logic exp_sat);
        down_ready = 1'b1;
        in_valid   = 1'b1;
        op_a       = a;
        op_b       = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_val({tag, "_lat1"}, {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_res"}, {8'd0, result}, {8'd0, exp_res});
        check_val({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
        check_val({tag, "_sat"}, {31'd0, sat}, {31'd0, exp_sat});
        if (exp_dz && exp_cnt != 255) exp_cnt++;
        @(negedge clk);
        check_val({tag, "_idle_v"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_idle_r"}, {8'd0, result}, 32'd0);
        check_val({tag, "_cnt"}, {24'd0, dz_count}, exp_cnt[31:0]);
    endtask

    logic [23:0] st_a   [5];
    logic [23:0] st_b   [5];
    logic [23:0] st_exp [5];

    initial begin
        logic [23:0] held_res;
        logic        held_dz;
        logic        held_sat;
        int          in_idx;
        int          out_idx;

        n_checks   = 0;
        n_fail     = 0;
        exp_cnt    = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        down_ready = 1'b1;
        op_a       = 24'h000000;
        op_b       = 24'h000000;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_result", {8'd0, result}, 32'd0);
        check_val("rst_flags", {30'd0, div_zero, sat}, 32'd0);
        check_val("rst_cnt", {24'd0, dz_count}, 32'd0);
        check_val("rst_ready", {31'd0, out_ready}, 32'd1);

        // First pair offered in the same step reset is released
        rst = 1'b0;
        run_single("basic", 24'h000010, 24'h000004, 24'h00000C, 1'b0, 1'b0);
        run_single("sat_pos", 24'h7FFFF0, 24'hFFFF00, 24'h7FFFFF, 1'b0, 1'b1);
        run_single("sat_neg", 24'h800001, 24'h000001, 24'h800001, 1'b0, 1'b1);
        run_single("dz_fin", 24'h000005, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0);
        run_single("dz_inf", 24'h800000, 24'h800000, 24'h800000, 1'b1, 1'b0);
        run_single("zero_num", 24'h800000, 24'h000003, 24'h800000, 1'b0, 1'b0);
        run_single("neg_diff", 24'h000001, 24'h000003, 24'hFFFFFE, 1'b0, 1'b0);
        run_single("min_edge", 24'h000000, 24'h7FFFFF, 24'h800001, 1'b0, 1'b0);
        run_single("max_edge", 24'h7FFFFE, 24'hFFFFFF, 24'h7FFFFF, 1'b0, 1'b0);

        // 300 back-to-back divide-by-zero transfers: counter must stick at 8'hFF
        down_ready = 1'b1;
        in_valid   = 1'b1;
        op_a       = 24'h000005;
        op_b       = 24'h800000;
        repeat (300) @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_cnt = (exp_cnt + 300 > 255) ? 255 : exp_cnt + 300;
        check_val("dz_sat_cnt", {24'd0, dz_count}, exp_cnt[31:0]);
        check_val("dz_sat_idle", {31'd0, out_valid}, 32'd0);

        // Stream of 5 pairs, downstream stalled for the first 4 cycles
        st_a[0] = 24'h000020; st_b[0] = 24'h000001; st_exp[0] = 24'h00001F;
        st_a[1] = 24'h000100; st_b[1] = 24'h000010; st_exp[1] = 24'h0000F0;
        st_a[2] = 24'hFFFFFF; st_b[2] = 24'h000001; st_exp[2] = 24'hFFFFFE;
        st_a[3] = 24'h000000; st_b[3] = 24'h000000; st_exp[3] = 24'h000000;
        st_a[4] = 24'h800000; st_b[4] = 24'h000007; st_exp[4] = 24'h800000;
        in_idx   = 0;
        out_idx  = 0;
        held_res = 24'h000000;
        held_dz  = 1'b0;
        held_sat = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            down_ready = (cyc >= 4);
            in_valid   = (in_idx < 5);
            op_a       = (in_idx < 5) ? st_a[in_idx] : 24'h000000;
            op_b       = (in_idx < 5) ? st_b[in_idx] : 24'h000000;
            #1;
            if (cyc == 2 || cyc == 3) begin
                check_val("stall_ready", {31'd0, out_ready}, 32'd0);
                check_val("stall_accepted", in_idx, 32'd2);
            end
            if (cyc == 3) begin
                check_val("stall_res_hold", {8'd0, result}, {8'd0, held_res});
                check_val("stall_flag_hold", {30'd0, div_zero, sat}, {30'd0, held_dz, held_sat});
            end
            if (out_valid) begin
                held_res = result;
                held_dz  = div_zero;
                held_sat = sat;
                if (down_ready) begin
                    if (out_idx < 5) begin
                        check_val("stream_res", {8'd0, result}, {8'd0, st_exp[out_idx]});
                        check_val("stream_flags", {30'd0, div_zero, sat}, 32'd0);
                    end else begin
                        check_val("stream_extra", out_idx, 32'd5);
                    end
                    out_idx++;
                end
            end
            if (in_valid && out_ready) in_idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("stream_in_count", in_idx, 32'd5);
        check_val("stream_out_count", out_idx, 32'd5);

        // Reset with both stages full: outputs clear asynchronously
        down_ready = 1'b0;
        in_valid   = 1'b1;
        op_a       = 24'h000010;
        op_b       = 24'h000004;
        @(negedge clk);
        op_a = 24'h000011;
        @(negedge clk);
        in_valid = 1'b0;
        check_val("full_valid", {31'd0, out_valid}, 32'd1);
        check_val("full_ready", {31'd0, out_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        exp_cnt = 0;
        check_val("arst_valid", {31'd0, out_valid}, 32'd0);
        check_val("arst_result", {8'd0, result}, 32'd0);
        check_val("arst_flags", {30'd0, div_zero, sat}, 32'd0);
        check_val("arst_cnt", {24'd0, dz_count}, 32'd0);
        check_val("arst_ready", {31'd0, out_ready}, 32'd1);
        @(negedge clk);
        rst        = 1'b0;
        down_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_val("no_spurious", {31'd0, out_valid}, 32'd0);
        end

        // Input accepted on the very first edge after another reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_single("post_rst", 24'h000003, 24'h800000, 24'h7FFFFF, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
